uart_rx: RTL

- Asynchronous serial receiver, 8N1, LSB first, idle-high line. It is the receive-side peer of uart_tx and shares its CLK_FREQUENCY/UART_FREQUENCY parameterisation.
- Deserialises one line into bytes and emits a one-cycle valid strobe per good frame.
- Feeds command decoding from the host rx pin.
- Also used in loopback benches against uart_tx.

---
 rtl/uart_rx.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : 8N1 asynchronous serial receiver, LSB first, idle-high line.
//                Emits a one-cycle valid strobe with the received byte, or a
//                one-cycle frame_error strobe when the stop bit reads low.
//  Ports       : user_clk    - system clock, rising edge
//                rst_n       - asynchronous active-low reset
//                rx_bit      - serial input, asynchronous to user_clk
//                data        - last good received byte, held between frames
//                valid       - one-cycle strobe, data updated same cycle
//                frame_error - one-cycle strobe on a low stop bit
//                busy        - high while a frame is being received
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int unsigned CLK_FREQUENCY  = 100000000,
    parameter int unsigned UART_FREQUENCY = 9600,
    parameter int unsigned DATA_SIZE      = 8
) (
    input  logic                 user_clk,
    input  logic                 rst_n,
    input  logic                 rx_bit,
    output logic [DATA_SIZE-1:0] data,
    output logic                 valid,
    output logic                 frame_error,
    output logic                 busy
);

    localparam int unsigned c_clks_per_bit = CLK_FREQUENCY / UART_FREQUENCY;
    localparam int unsigned c_half_bit     = c_clks_per_bit / 2;
    localparam int unsigned c_cnt_w        = (c_clks_per_bit > 1) ? $clog2(c_clks_per_bit) : 1;
    localparam int unsigned c_idx_w        = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;

    localparam logic [c_cnt_w-1:0] c_bit_last  = c_cnt_w'(c_clks_per_bit - 1);
    localparam logic [c_cnt_w-1:0] c_half_last = c_cnt_w'(c_half_bit - 1);
    localparam logic [c_idx_w-1:0] c_idx_last  = c_idx_w'(DATA_SIZE - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [1:0]             sync_q;
    logic [c_cnt_w-1:0]     cnt_q, cnt_d;
    logic [c_idx_w-1:0]     idx_q, idx_d;
    logic [DATA_SIZE-1:0]   shift_q, shift_d;
    logic [DATA_SIZE-1:0]   data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   frame_error_q, frame_error_d;
    logic                   busy_q, busy_d;
    logic                   rx_s;

    // Second synchroniser stage is the only view of the line the FSM uses.
    assign rx_s = sync_q[1];

    always_ff @(posedge user_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q        <= 2'b11;
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            idx_q         <= '0;
            shift_q       <= '0;
            data_q        <= '0;
            valid_q       <= 1'b0;
            frame_error_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            sync_q        <= {sync_q[0], rx_bit};
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            shift_q       <= shift_d;
            data_q        <= data_d;
            valid_q       <= valid_d;
            frame_error_q <= frame_error_d;
            busy_q        <= busy_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        shift_d       = shift_q;
        data_d        = data_q;
        valid_d       = 1'b0;
        frame_error_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                end
            end

            // Re-check the start bit at its midpoint to reject short glitches.
            ST_START: begin
                if (cnt_q == c_half_last) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        state_d = ST_DATA;
                        idx_d   = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_DATA: begin
                if (cnt_q == c_bit_last) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s;
                    if (idx_q == c_idx_last) begin
                        state_d = ST_STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            // Leaving at mid-stop-bit lets a start edge right after the stop
            // bit be seen by IDLE.
            ST_STOP: begin
                if (cnt_q == c_bit_last) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        frame_error_d = 1'b1;
                        state_d       = ST_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            // Hold off until the line returns high so a break reports once.
            ST_BREAK: begin
                if (rx_s) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign data        = data_q;
    assign valid       = valid_q;
    assign frame_error = frame_error_q;
    assign busy        = busy_q;

endmodule
`default_nettype wire
